// File: rtl/sr_chk_pkg.sv
// Shared types and helpers for the SR latch response checker.
// State numbering is visible on exp_state: 0 UNKNOWN, 1 ZERO, 2 ONE, 3 FORBID.
package sr_chk_pkg;

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_ZERO    = 2'd1,
    ST_ONE     = 2'd2,
    ST_FORBID  = 2'd3
  } sr_state_t;

  // Expected {q, qb} for the states that pin the latch outputs.
  localparam logic [1:0] QQB_ZERO   = 2'b01;
  localparam logic [1:0] QQB_ONE    = 2'b10;
  localparam logic [1:0] QQB_FORBID = 2'b00;

  // Wide enough for the largest legal SETTLE (15).
  localparam int STABLE_W = 4;

  function automatic sr_state_t sr_next_state(input sr_state_t cur, input logic [1:0] sr);
    sr_state_t nxt;
    nxt = cur;
    case (sr)
      2'b10:   nxt = ST_ONE;
      2'b01:   nxt = ST_ZERO;
      2'b11:   nxt = ST_FORBID;
      default: if (cur == ST_FORBID) nxt = ST_UNKNOWN;  // release from s=r=1 races
    endcase
    return nxt;
  endfunction

  function automatic logic qqb_mismatch(input sr_state_t st, input logic [1:0] qqb);
    logic bad;
    bad = 1'b0;
    case (st)
      ST_ZERO:   bad = (qqb != QQB_ZERO);
      ST_ONE:    bad = (qqb != QQB_ONE);
      ST_FORBID: bad = (qqb != QQB_FORBID);
      default:   bad = (qqb[1] == qqb[0]);  // either stored value is fine, but q must differ from qb
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sr_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sr_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    // NOTE: default assigned first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values.
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sr_latch_checker.sv
// Clocked checker for a NOR SR latch: models expected state, compares q/qb once s/r have settled.
// Build option SR_CHK_FORBID_ERR_EN: entering s=r=1 also counts as an error.
module sr_latch_checker
  import sr_chk_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qb,
  output logic [1:0]       exp_state,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] forbid_count
);

  localparam logic [STABLE_W-1:0] SETTLE_C = STABLE_W'(SETTLE);

  logic [1:0]          sr_q;
  logic [1:0]          sr_prev_q;
  logic [1:0]          qqb_q;
  logic [1:0]          qqb_dly_q;
  logic [STABLE_W-1:0] stable_q;
  logic [STABLE_W-1:0] stable_d;
  sr_state_t           state_q;
  sr_state_t           state_d;
  logic                err_sticky_q;
  logic                err_sticky_d;
  logic                mismatch;
  logic                forbid_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= '0;
      sr_prev_q    <= '0;
      qqb_q        <= '0;
      qqb_dly_q    <= '0;
      stable_q     <= '0;
      state_q      <= ST_UNKNOWN;
      err_sticky_q <= 1'b0;
    end else begin
      sr_q         <= {s, r};
      sr_prev_q    <= sr_q;
      qqb_q        <= {q, qb};
      qqb_dly_q    <= qqb_q;
      stable_q     <= stable_d;
      state_q      <= state_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // state_q and stable_q both describe the sample held one cycle earlier, so the
  // latch response is compared through qqb_dly_q, taken alongside that same sample.
  always_comb begin
    state_d  = sr_next_state(state_q, sr_q);
    stable_d = stable_q;
    if (sr_q != sr_prev_q) begin
      stable_d = '0;
    end else if (stable_q != SETTLE_C) begin
      stable_d = stable_q + 1'b1;
    end

    mismatch     = (stable_q == SETTLE_C) && qqb_mismatch(state_q, qqb_dly_q);
    forbid_entry = (sr_q == 2'b11) && (state_q != ST_FORBID);

`ifdef SR_CHK_FORBID_ERR_EN
    err_pulse = mismatch | forbid_entry;
`else
    err_pulse = mismatch;
`endif

    err_sticky_d = err_sticky_q | err_pulse;
  end

  sr_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .inc_i   (err_pulse),
    .count_o (err_count)
  );

  sr_sat_counter #(.W(CNT_W)) u_forbid_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .inc_i   (forbid_entry),
    .count_o (forbid_count)
  );

  assign exp_state  = state_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sr_latch_checker.sv
// Self-checking bench for sr_latch_checker: directed scenarios plus random s/r traffic,
// every cycle compared against a history-based reference model.
module tb_sr_latch_checker;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

`ifdef SR_CHK_FORBID_ERR_EN
  localparam bit FORBID_ERR = 1'b1;
`else
  localparam bit FORBID_ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s, r, q, qb;
  logic [1:0]       exp_state;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] forbid_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Sampled {s,r,q,qb} per edge since reset; two leading entries stand for the reset contents.
  logic [3:0] hist[$];
  logic       lq, lqb;
  int         m_err, m_forbid;
  bit         m_sticky, pend_err, pend_forbid;

  sr_latch_checker #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s            (s),
    .r            (r),
    .q            (q),
    .qb           (qb),
    .exp_state    (exp_state),
    .err_pulse    (err_pulse),
    .err_sticky   (err_sticky),
    .err_count    (err_count),
    .forbid_count (forbid_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural NOR latch driving q/qb; mode 1 forces q=0,qb=1, mode 2 inverts q.
  task automatic drive(input logic si, input logic ri, input int mode);
    s = si;
    r = ri;
    if (si && !ri)       begin lq = 1'b1; lqb = 1'b0; end
    else if (!si && ri)  begin lq = 1'b0; lqb = 1'b1; end
    else if (si && ri)   begin lq = 1'b0; lqb = 1'b0; end
    else if (!lq && !lqb) begin
      lq  = 1'($urandom_range(0, 1));
      lqb = ~lq;
    end
    case (mode)
      1:       begin q = 1'b0; qb = 1'b1; end
      2:       begin q = ~lq;  qb = lqb;  end
      default: begin q = lq;   qb = lqb;  end
    endcase
  endtask

  // Expected outputs for the cycle after the latest edge, folded from the sample history.
  task automatic evaluate();
    int         k;
    int         st;
    int         run;
    logic [1:0] qqb;
    bit         good;
    bit         entry;
    k   = hist.size() - 2;
    st  = 0;
    run = 0;
    for (int i = 2; i <= k; i++) begin
      case (hist[i][3:2])
        2'b10:   st = 2;
        2'b01:   st = 1;
        2'b11:   st = 3;
        default: if (st == 3) st = 0;
      endcase
    end
    for (int i = k; i >= 1; i--) begin
      if (hist[i][3:2] != hist[i-1][3:2]) break;
      run++;
    end
    qqb = hist[k][1:0];
    case (st)
      2:       good = (qqb == 2'b10);
      1:       good = (qqb == 2'b01);
      3:       good = (qqb == 2'b00);
      default: good = (qqb[1] != qqb[0]);
    endcase
    entry       = (hist[k+1][3:2] == 2'b11) && (st != 3);
    pend_err    = ((run >= SETTLE) && !good) || (FORBID_ERR && entry);
    pend_forbid = entry;
    check("exp_state",    32'(exp_state),    32'(st));
    check("err_pulse",    32'(err_pulse),    32'(pend_err));
    check("err_sticky",   32'(err_sticky),   32'(m_sticky));
    check("err_count",    32'(err_count),    32'(m_err));
    check("forbid_count", 32'(forbid_count), 32'(m_forbid));
  endtask

  task automatic step(input logic si, input logic ri, input int mode);
    drive(si, ri, mode);
    @(posedge clk);
    if (pend_err) begin
      m_sticky = 1'b1;
      if (m_err < CMAX) m_err++;
    end
    if (pend_forbid && m_forbid < CMAX) m_forbid++;
    hist.push_back({si, ri, q, qb});
    @(negedge clk);
    evaluate();
  endtask

  task automatic hold(input logic si, input logic ri, input int mode, input int n);
    for (int i = 0; i < n; i++) step(si, ri, mode);
  endtask

  // Asserted between edges: outputs must clear without any clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_state",  32'(exp_state),    0);
    check("rst_pulse",  32'(err_pulse),    0);
    check("rst_sticky", 32'(err_sticky),   0);
    check("rst_err",    32'(err_count),    0);
    check("rst_forbid", 32'(forbid_count), 0);
    hist.delete();
    hist.push_back(4'b0000);
    hist.push_back(4'b0000);
    m_err       = 0;
    m_forbid    = 0;
    m_sticky    = 1'b0;
    pend_err    = 1'b0;
    pend_forbid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first;
    int hl;
    logic [1:0] sr;
    rst_n = 1'b1;
    s = 1'b0; r = 1'b0; lq = 1'b0; lqb = 1'b1; q = 1'b0; qb = 1'b1;
    do_reset();

    // Correct latch through set/reset/hold.
    hold(1'b0, 1'b0, 0, 10);
    hold(1'b1, 1'b0, 0, 10);
    hold(1'b0, 1'b0, 0, 10);
    hold(1'b0, 1'b1, 0, 10);
    hold(1'b0, 1'b0, 0, 10);
    check("t1_err",    32'(err_count),    0);
    check("t1_state",  32'(exp_state),    1);
    check("t1_forbid", 32'(forbid_count), 0);

    // Outputs stuck at ZERO while set is held: first pulse three cycles after the change.
    do_reset();
    hold(1'b0, 1'b0, 0, 4);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1);
      if (err_pulse && first < 0) first = i;
    end
    hold(1'b0, 1'b0, 0, 4);
    check("t2_first_pulse", 32'(first),     3);
    check("t2_err",         32'(err_count), 8);

    // Forbidden input then release.
    do_reset();
    hold(1'b0, 1'b0, 0, 3);
    hold(1'b1, 1'b1, 0, 5);
    hold(1'b0, 1'b0, 0, 10);
    check("t3_forbid", 32'(forbid_count), 1);
    check("t3_state",  32'(exp_state),    0);
    check("t3_err",    32'(err_count),    FORBID_ERR ? 1 : 0);
    check("t3_sticky", 32'(err_sticky),   FORBID_ERR ? 1 : 0);

    // Never-settling stimulus with a wrong latch.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'(i % 2 == 0), 1'b0, 2);
    check("t4_err", 32'(err_count), 0);

    // Saturation.
    do_reset();
    hold(1'b1, 1'b0, 1, 40);
    check("t5_err",    32'(err_count),  CMAX);
    check("t5_sticky", 32'(err_sticky), 1);

    // Mid-run reset (checked inside do_reset), then random traffic.
    do_reset();
    for (int n = 0; n < 120; n++) begin
      sr = 2'($urandom_range(0, 3));
      hl = $urandom_range(1, 5);
      hold(sr[1], sr[0], ($urandom_range(0, 7) == 0) ? 2 : 0, hl);
      if (n == 60) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
